ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit_pkg.sv | 29 ++
 rtl/ex_muldiv_unit_step.sv | 35 +++
 rtl/ex_muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit: op and
// FSM encodings, iteration count and sign-correction helpers.
package ex_muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } mdOp_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdState_e;

   localparam int unsigned ITER_COUNT = 32;
   localparam logic [4:0]  LAST_ITER  = 5'(ITER_COUNT - 1);

   function automatic logic [31:0] condNeg32(input logic [31:0] val, input logic neg);
      return neg ? (~val + 32'd1) : val;
   endfunction

   function automatic logic [63:0] condNeg64(input logic [63:0] val, input logic neg);
      return neg ? (~val + 64'd1) : val;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One iteration of the unsigned multiply (shift-add) or restoring divide
// (shift-subtract) on the {accHi, accLo} accumulator pair.
module muldiv_step (
   input  logic        isDiv,
   input  logic [31:0] accHi,
   input  logic [31:0] accLo,
   input  logic [31:0] operand,
   output logic [31:0] nextHi,
   output logic [31:0] nextLo
);

   logic [32:0] sum_s;
   logic [32:0] shifted_s;
   logic [32:0] diff_s;

   // Remainder stays below the divisor, so the 33-bit trial difference cannot overflow.
   always_comb begin
      sum_s     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : 33'd0);
      shifted_s = {accHi, accLo[31]};
      diff_s    = shifted_s - {1'b0, operand};
      if (isDiv) begin
         if (diff_s[32]) begin
            nextHi = shifted_s[31:0];
            nextLo = {accLo[30:0], 1'b0};
         end else begin
            nextHi = diff_s[31:0];
            nextLo = {accLo[30:0], 1'b1};
         end
      end else begin
         nextHi = sum_s[32:1];
         nextLo = {sum_s[0], accLo[31:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        cancel,
   input  logic        hi_wr,
   input  logic        lo_wr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdState_e    state_r;
   logic [4:0]  iterCnt_r;
   logic        isDiv_r, resSign_r, remSign_r, divZero_r, busy_r, done_r;
   logic [31:0] opB_r, accHi_r, accLo_r, hi_r, lo_r;
   logic        signedOp_s, aNeg_s, bNeg_s;
   logic [31:0] aMag_s, bMag_s, stepHi_s, stepLo_s, fixHi_s, fixLo_s;
   logic [63:0] fixProd_s;

   // Operand magnitudes for the unsigned datapath
   always_comb begin
      signedOp_s = (op == MD_MULT) || (op == MD_DIV);
      aNeg_s     = signedOp_s & operand_a[31];
      bNeg_s     = signedOp_s & operand_b[31];
      aMag_s     = condNeg32(operand_a, aNeg_s);
      bMag_s     = condNeg32(operand_b, bNeg_s);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fastProd_s;

   // Single-cycle magnitude product
   always_comb begin
      fastProd_s = 64'(aMag_s) * 64'(bMag_s);
   end
`endif

   muldiv_step uStep (
      .isDiv   (isDiv_r),
      .accHi   (accHi_r),
      .accLo   (accLo_r),
      .operand (opB_r),
      .nextHi  (stepHi_s),
      .nextLo  (stepLo_s)
   );

   // Sign correction; the remainder magnitude of a zero divide is |a|, so HI restores a
   always_comb begin
      fixProd_s = condNeg64({accHi_r, accLo_r}, resSign_r);
      if (isDiv_r) begin
         fixHi_s = condNeg32(accHi_r, remSign_r);
         if (divZero_r) begin
            fixLo_s = 32'hFFFF_FFFF;
         end else begin
            fixLo_s = condNeg32(accLo_r, resSign_r);
         end
      end else begin
         fixHi_s = fixProd_s[63:32];
         fixLo_s = fixProd_s[31:0];
      end
   end

   // Control FSM, iteration counter, accumulators and HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         iterCnt_r <= 5'd0;
         isDiv_r   <= 1'b0;
         resSign_r <= 1'b0;
         remSign_r <= 1'b0;
         divZero_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         opB_r     <= 32'd0;
         accHi_r   <= 32'd0;
         accLo_r   <= 32'd0;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
      end else begin
         done_r <= 1'b0;
         if (cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     isDiv_r   <= op[1];
                     resSign_r <= aNeg_s ^ bNeg_s;
                     remSign_r <= aNeg_s;
                     divZero_r <= (operand_b == 32'd0);
                     iterCnt_r <= 5'd0;
                     busy_r    <= 1'b1;
                     if (op[1]) begin
                        accHi_r <= 32'd0;
                        accLo_r <= aMag_s;
                        opB_r   <= bMag_s;
                        state_r <= CALC;
                     end else begin
`ifdef MULDIV_FAST_MUL_EN
                        accHi_r <= fastProd_s[63:32];
                        accLo_r <= fastProd_s[31:0];
                        opB_r   <= aMag_s;
                        state_r <= FIX;
`else
                        accHi_r <= 32'd0;
                        accLo_r <= bMag_s;
                        opB_r   <= aMag_s;
                        state_r <= CALC;
`endif
                     end
                  end
               end
               CALC: begin
                  accHi_r <= stepHi_s;
                  accLo_r <= stepLo_s;
                  if (iterCnt_r == LAST_ITER) begin
                     state_r <= FIX;
                  end else begin
                     iterCnt_r <= iterCnt_r + 5'd1;
                  end
               end
               FIX: begin
                  hi_r    <= fixHi_s;
                  lo_r    <= fixLo_s;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
         if ((state_r == IDLE) && !start) begin
            if (hi_wr) begin
               hi_r <= wdata;
            end
            if (lo_wr) begin
               lo_r <= wdata;
            end
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, cancel, hi_wr, lo_wr;
   logic [1:0]  op;
   logic [31:0] operand_a, operand_b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [63:0] sbQ[$];

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
   localparam logic [1:0] CANCEL_OP = MD_DIVU;
`else
   localparam int MUL_LAT = 33;
   localparam logic [1:0] CANCEL_OP = MD_MULTU;
`endif
   localparam int DIV_LAT = 33;

   ex_muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference arithmetic: {HI, LO}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         MD_MULT:  return 64'(sa * sb);
         MD_MULTU: return {32'd0, a} * {32'd0, b};
         MD_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         MD_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Caller is positioned just after a falling edge.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv, input int lat,
                        input bit disturb);
      int cyc;
      logic seen, busyOk;
      logic [31:0] hiBefore, loBefore;
      hiBefore = hi;
      loBefore = lo;
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      sbQ.push_back(expv);
      cyc = 0; seen = 1'b0; busyOk = 1'b1;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         hi_wr = 1'b0;
         if (disturb && cyc == 6) begin
            checkVal({tag, "_mthi_busy"}, {hi, lo}, {hiBefore, loBefore});
         end
         if (done) begin
            seen = 1'b1;
         end else begin
            if (!busy) busyOk = 1'b0;
            if (disturb && cyc == 5) begin
               start = 1'b1; op = MD_MULTU; operand_a = 32'd9; operand_b = 32'd9;
               hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
            end
         end
      end
      checkVal({tag, "_done"}, 64'(seen), 64'd1);
      if (seen) begin
         checkVal({tag, "_lat"}, 64'(cyc - 1), 64'(lat));
         checkVal({tag, "_busy"}, {62'd0, busyOk, busy}, 64'd2);
         checkVal(tag, {hi, lo}, sbQ.pop_front());
         @(negedge clk);
         checkVal({tag, "_pulse"}, 64'(done), 64'd0);
      end else begin
         sbQ.delete();
      end
   endtask

   initial begin
      logic seenDone;
      logic [1:0] rop;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      op = 2'b00; operand_a = 32'd0; operand_b = 32'd0; wdata = 32'd0;
      #2 reset = 1'b0;
      #1;
      checkVal("rst_out", {30'd0, busy, done, hi}, 64'd0);
      checkVal("rst_lo", 64'(lo), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // MTHI in IDLE
      hi_wr = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk);
      hi_wr = 1'b0;
      checkVal("mthi", {hi, lo}, {32'hCAFE_F00D, 32'd0});

      runOp("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT, 1'b0);
      runOp("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT, 1'b0);
      runOp("divu_7_2", MD_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, DIV_LAT, 1'b0);
      runOp("divu_zero", MD_DIVU, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, DIV_LAT, 1'b0);
      runOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_LAT, 1'b0);
      runOp("div_zero_neg", MD_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, DIV_LAT, 1'b0);
      runOp("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, DIV_LAT, 1'b0);
      runOp("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, 1'b0);
      runOp("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT, 1'b0);
      runOp("divu_busy", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT, 1'b1);

      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : $urandom;
         runOp("rand", rop, ra, rb, model(rop, ra, rb), rop[1] ? DIV_LAT : MUL_LAT, 1'b0);
      end

      // Cancel at iteration 10 with HI=LO=0x55555555
      hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h5555_5555;
      @(negedge clk);
      hi_wr = 1'b0; lo_wr = 1'b0;
      start = 1'b1; op = CANCEL_OP; operand_a = 32'h0001_2345; operand_b = 32'd77;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      checkVal("cancel_busy", 64'(busy), 64'd0);
      seenDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seenDone = seenDone | done;
      end
      checkVal("cancel_done", 64'(seenDone), 64'd0);
      checkVal("cancel_hilo", {hi, lo}, 64'h5555_5555_5555_5555);

      // start and cancel together in IDLE
      start = 1'b1; cancel = 1'b1; op = MD_DIVU; operand_a = 32'd9; operand_b = 32'd3;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      checkVal("stcan_busy", 64'(busy), 64'd0);
      seenDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seenDone = seenDone | done;
      end
      checkVal("stcan_done", 64'(seenDone), 64'd0);
      checkVal("stcan_hilo", {hi, lo}, 64'h5555_5555_5555_5555);

      // Asynchronous reset mid-DIV
      start = 1'b1; op = MD_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      checkVal("pre_rst_busy", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      checkVal("arst_out", {30'd0, busy, done, hi}, 64'd0);
      checkVal("arst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      runOp("post_rst", MD_MULTU, 32'd5, 32'd6, {32'd0, 32'd30}, MUL_LAT, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
